// File: rtl/note_judge.sv
// -----------------------------------------------------------------------------
// note_judge
//
// Purpose:
//   Rhythm-game judging core. Walks the chart ROM with a look-ahead window of
//   four words, keeps the song frame counter, matches lane presses against the
//   visible notes and emits one PERFECT / GOOD / MISS judgment per note.
//   Score and combo are updated in the same cycle that the judgment strobe is
//   high.
//
// Ports:
//   Clk, Reset_n        clock, synchronous active-low reset
//   start               one-cycle pulse, (re)starts the song from frame 0
//   frame_tick          one-cycle pulse per video frame
//   key_hit[2:0]        one-cycle press pulses, one bit per lane
//   addr[7:0]           chart ROM address (window base)
//   key_1..key_4[15:0]  chart words at addr..addr+3 ([15:14] lane, [13:0] frame)
//   frame_cnt[13:0]     current song frame (saturating)
//   judge_valid         one-cycle judgment strobe
//   judge_code[1:0]     01 PERFECT, 10 GOOD, 11 MISS, 00 when not valid
//   judge_lane[1:0]     lane of the judged note (held between judgments)
//   score[15:0]         saturating score
//   combo[9:0]          saturating combo count
//   done                high while the song is finished
//
// Configuration macro:
//   NOTE_JUDGE_GHOST_EN  when defined, a press that matches no note produces a
//                        MISS strobe on the pressed lane and breaks the combo;
//                        when undefined such presses are silently dropped.
// -----------------------------------------------------------------------------
module note_judge #(
   parameter int CHART_LEN   = 112,
   parameter int PERFECT_WIN = 3,
   parameter int GOOD_WIN    = 6,
   parameter int PERFECT_PTS = 100,
   parameter int GOOD_PTS    = 50
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        start,
   input  logic        frame_tick,
   input  logic [2:0]  key_hit,
   output logic [7:0]  addr,
   input  logic [15:0] key_1,
   input  logic [15:0] key_2,
   input  logic [15:0] key_3,
   input  logic [15:0] key_4,
   output logic [13:0] frame_cnt,
   output logic        judge_valid,
   output logic [1:0]  judge_code,
   output logic [1:0]  judge_lane,
   output logic [15:0] score,
   output logic [9:0]  combo,
   output logic        done
);

   localparam logic [8:0]  LEN9 = 9'(CHART_LEN);
   localparam logic [14:0] PWIN = 15'(PERFECT_WIN);
   localparam logic [14:0] GWIN = 15'(GOOD_WIN);

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_PERFECT = 2'b01;
   localparam logic [1:0] CODE_GOOD    = 2'b10;
   localparam logic [1:0] CODE_MISS    = 2'b11;
   localparam logic [1:0] LANE_INVALID = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [9:0] sat_inc10(input logic [9:0] a);
      return (a == 10'h3FF) ? a : a + 10'd1;
   endfunction

   // Frame error taken at 15 bits signed so that both directions fit, then
   // folded to a magnitude.
   function automatic logic [14:0] abs_err(input logic [13:0] f, input logic [13:0] t);
      logic signed [14:0] d;
      d = $signed({1'b0, f}) - $signed({1'b0, t});
      if (d[14]) return 15'(-d);
      return 15'(d);
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic [13:0] frame_q, frame_d;
   logic [3:0]  mask_q, mask_d;
   logic [2:0]  pend_q, pend_d;
   logic        jv_q, jv_d;
   logic [1:0]  jc_q, jc_d;
   logic [1:0]  jl_q, jl_d;
   logic [15:0] score_q, score_d;
   logic [9:0]  combo_q, combo_d;

   logic [15:0] slot [4];
   logic [14:0] err  [4];
   logic [3:0]  vis;

   logic        advance;
   logic        found;
   logic [1:0]  hit_k;
   logic [1:0]  hit_lane;
   logic [2:0]  pend_left;
   logic [3:0]  set_v;

   assign slot[0] = key_1;
   assign slot[1] = key_2;
   assign slot[2] = key_3;
   assign slot[3] = key_4;

   // Per-slot visibility (inside the valid chart) and frame error.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         vis[k] = (({1'b0, addr_q} + 9'(k)) < LEN9);
         err[k] = abs_err(frame_q, slot[k][13:0]);
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      frame_d   = frame_q;
      mask_d    = mask_q;
      pend_d    = 3'b000;
      jv_d      = 1'b0;
      jc_d      = CODE_NONE;
      jl_d      = jl_q;
      score_d   = score_q;
      combo_d   = combo_q;
      advance   = 1'b0;
      found     = 1'b0;
      hit_k     = 2'd0;
      hit_lane  = 2'd0;
      pend_left = pend_q;
      set_v     = 4'b0000;

      // start behaves identically from every state; presses are not kept.
      if (start) begin
         state_d = S_RUN;
         addr_d  = '0;
         frame_d = '0;
         mask_d  = '0;
         score_d = '0;
         combo_d = '0;
      end else begin
         case (state_q)
            S_RUN: begin
               if ({1'b0, addr_q} == LEN9) begin
                  state_d = S_DONE;
               end else begin
                  if (frame_tick && (frame_q != 14'h3FFF)) frame_d = frame_q + 14'd1;

                  advance = mask_q[0] | (slot[0][15:14] == LANE_INVALID);

                  if (pend_q != 3'b000) begin
                     if (pend_q[0])      hit_lane = 2'd0;
                     else if (pend_q[1]) hit_lane = 2'd1;
                     else                hit_lane = 2'd2;
                     pend_left[hit_lane] = 1'b0;

                     // Scan from the top so the lowest matching slot wins.
                     for (int k = 3; k >= 0; k--) begin
                        if (vis[k] && !mask_q[k] && (slot[k][15:14] == hit_lane) &&
                            (err[k] <= GWIN)) begin
                           found = 1'b1;
                           hit_k = 2'(k);
                        end
                     end

                     if (found) begin
                        set_v[hit_k] = 1'b1;
                        jv_d    = 1'b1;
                        jl_d    = hit_lane;
                        combo_d = sat_inc10(combo_q);
                        if (err[hit_k] <= PWIN) begin
                           jc_d    = CODE_PERFECT;
                           score_d = sat_add16(score_q, 16'(PERFECT_PTS));
                        end else begin
                           jc_d    = CODE_GOOD;
                           score_d = sat_add16(score_q, 16'(GOOD_PTS));
                        end
                     end else begin
`ifdef NOTE_JUDGE_GHOST_EN
                        jv_d    = 1'b1;
                        jc_d    = CODE_MISS;
                        jl_d    = hit_lane;
                        combo_d = '0;
`endif
                     end
                  end else if (vis[0] && !mask_q[0] && (slot[0][15:14] != LANE_INVALID) &&
                               ({1'b0, frame_q} > ({1'b0, slot[0][13:0]} + GWIN))) begin
                     set_v[0] = 1'b1;
                     jv_d     = 1'b1;
                     jc_d     = CODE_MISS;
                     jl_d     = slot[0][15:14];
                     combo_d  = '0;
                  end

                  // A hit never lands on slot 0 while advancing (slot 0 is then
                  // consumed or invalid), so set-then-shift is safe.
                  if (advance) begin
                     addr_d = addr_q + 8'd1;
                     mask_d = (mask_q | set_v) >> 1;
                  end else begin
                     mask_d = mask_q | set_v;
                  end

                  pend_d = pend_left | key_hit;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         frame_q <= '0;
         mask_q  <= '0;
         pend_q  <= '0;
         jv_q    <= 1'b0;
         jc_q    <= CODE_NONE;
         jl_q    <= '0;
         score_q <= '0;
         combo_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         frame_q <= frame_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         jv_q    <= jv_d;
         jc_q    <= jc_d;
         jl_q    <= jl_d;
         score_q <= score_d;
         combo_q <= combo_d;
      end
   end

   assign addr        = addr_q;
   assign frame_cnt   = frame_q;
   assign judge_valid = jv_q;
   assign judge_code  = jc_q;
   assign judge_lane  = jl_q;
   assign score       = score_q;
   assign combo       = combo_q;
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_note_judge.sv
// -----------------------------------------------------------------------------
// tb_note_judge
//
// Bench for note_judge with a four-note chart. A behavioural model tracks the
// song as a list of notes with per-note consumed flags (absolute chart index),
// a pending-press set and the score/combo rules, and is compared with every
// DUT output after every clock. Directed scenarios add constant expectations
// for the headline cases; a randomized section drives random charts, ticks,
// presses, restarts and resets.
// -----------------------------------------------------------------------------
module tb_note_judge;

   localparam int CL = 4;
   localparam int PW = 3;
   localparam int GW = 6;
   localparam int PP = 100;
   localparam int GP = 50;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        start = 1'b0;
   logic        frame_tick = 1'b0;
   logic [2:0]  key_hit = 3'b000;
   logic [7:0]  addr;
   logic [15:0] key_1, key_2, key_3, key_4;
   logic [13:0] frame_cnt;
   logic        judge_valid;
   logic [1:0]  judge_code;
   logic [1:0]  judge_lane;
   logic [15:0] score;
   logic [9:0]  combo;
   logic        done;

   logic [15:0] mem [0:255];

   assign key_1 = mem[addr];
   assign key_2 = mem[addr + 8'd1];
   assign key_3 = mem[addr + 8'd2];
   assign key_4 = mem[addr + 8'd3];

   always #5 Clk = ~Clk;

   note_judge #(
      .CHART_LEN(CL), .PERFECT_WIN(PW), .GOOD_WIN(GW),
      .PERFECT_PTS(PP), .GOOD_PTS(GP)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_tick(frame_tick),
      .key_hit(key_hit), .addr(addr),
      .key_1(key_1), .key_2(key_2), .key_3(key_3), .key_4(key_4),
      .frame_cnt(frame_cnt), .judge_valid(judge_valid), .judge_code(judge_code),
      .judge_lane(judge_lane), .score(score), .combo(combo), .done(done)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model state: 0 idle, 1 running, 2 finished.
   int         m_st = 0, m_fc = 0, m_ptr = 0, m_score = 0, m_combo = 0;
   int         m_jc = 0, m_jl = 0;
   bit         m_jv = 1'b0;
   logic [2:0] m_pend = 3'b000;
   bit         m_cons [0:255];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic song_restart();
      m_st = 1; m_fc = 0; m_ptr = 0; m_score = 0; m_combo = 0; m_pend = 3'b000;
      for (int i = 0; i < 256; i++) m_cons[i] = 1'b0;
   endtask

   task automatic model_step(input bit rn, input bit s, input bit tk, input logic [2:0] kh);
      int cur_fc, cur_ptr, lane, t, e, hk, herr;
      bit adv;
      logic [2:0] pl;
      m_jv = 1'b0;
      m_jc = 0;
      if (!rn) begin
         m_st = 0; m_fc = 0; m_ptr = 0; m_score = 0; m_combo = 0; m_jl = 0; m_pend = 3'b000;
         for (int i = 0; i < 256; i++) m_cons[i] = 1'b0;
         return;
      end
      if (s) begin
         song_restart();
         return;
      end
      if (m_st != 1) begin
         m_pend = 3'b000;
         return;
      end
      if (m_ptr == CL) begin
         m_st = 2;
         m_pend = 3'b000;
         return;
      end
      cur_fc  = m_fc;
      cur_ptr = m_ptr;
      pl      = m_pend;
      if (tk && m_fc < 16383) m_fc++;
      adv = m_cons[cur_ptr] || (mem[cur_ptr][15:14] == 2'b11);
      if (pl != 3'b000) begin
         lane = pl[0] ? 0 : (pl[1] ? 1 : 2);
         pl[lane] = 1'b0;
         hk = -1;
         herr = 0;
         for (int k = 0; k < 4; k++) begin
            if (hk < 0 && (cur_ptr + k) < CL && !m_cons[cur_ptr + k] &&
                int'(mem[cur_ptr + k][15:14]) == lane) begin
               t = int'(mem[cur_ptr + k][13:0]);
               e = cur_fc - t;
               if (e < 0) e = -e;
               if (e <= GW) begin
                  hk = k;
                  herr = e;
               end
            end
         end
         if (hk >= 0) begin
            m_cons[cur_ptr + hk] = 1'b1;
            m_jv = 1'b1;
            m_jl = lane;
            m_jc = (herr <= PW) ? 1 : 2;
            m_score = m_score + ((herr <= PW) ? PP : GP);
            if (m_score > 65535) m_score = 65535;
            if (m_combo < 1023) m_combo++;
         end else begin
`ifdef NOTE_JUDGE_GHOST_EN
            m_jv = 1'b1;
            m_jc = 3;
            m_jl = lane;
            m_combo = 0;
`endif
         end
      end else if (!m_cons[cur_ptr] && mem[cur_ptr][15:14] != 2'b11 &&
                   cur_fc > int'(mem[cur_ptr][13:0]) + GW) begin
         m_cons[cur_ptr] = 1'b1;
         m_jv = 1'b1;
         m_jc = 3;
         m_jl = int'(mem[cur_ptr][15:14]);
         m_combo = 0;
      end
      if (adv) m_ptr++;
      m_pend = pl | kh;
   endtask

   task automatic compare_all();
      chk("judge_valid", 32'(judge_valid), 32'(m_jv));
      chk("judge_code",  32'(judge_code),  m_jc);
      chk("judge_lane",  32'(judge_lane),  m_jl);
      chk("score",       32'(score),       m_score);
      chk("combo",       32'(combo),       m_combo);
      chk("addr",        32'(addr),        m_ptr);
      chk("frame_cnt",   32'(frame_cnt),   m_fc);
      chk("done",        32'(done),        32'(m_st == 2));
   endtask

   task automatic cyc(input bit s, input bit tk, input logic [2:0] kh);
      start = s;
      frame_tick = tk;
      key_hit = kh;
      model_step(Reset_n, s, tk, kh);
      @(posedge Clk);
      #1;
      start = 1'b0;
      frame_tick = 1'b0;
      key_hit = 3'b000;
      compare_all();
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      cyc(1'b0, 1'b0, 3'b000);
      Reset_n = 1'b1;
   endtask

   // Tick until the model frame reaches f, bounded so a frozen counter cannot hang.
   task automatic run_to(input int f);
      for (int i = 0; i < 20000 && m_fc < f; i++) cyc(1'b0, 1'b1, 3'b000);
   endtask

   task automatic load_chart(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
      mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
      // Padding deliberately looks like playable notes around the test frames.
      for (int i = 4; i < 256; i++) mem[i] = {2'(i % 3), 14'd70};
   endtask

   initial begin
      load_chart(16'h0047, 16'h01F4, 16'h41F4, 16'h81F4);

      // Reset state
      do_reset();
      chk("rst_valid", 32'(judge_valid), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_done", 32'(done), 0);

      // PERFECT at frame 71, then the window advances one cycle after the strobe
      cyc(1'b1, 1'b0, 3'b000);
      run_to(71);
      cyc(1'b0, 1'b0, 3'b001);
      cyc(1'b0, 1'b0, 3'b000);
      chk("perf_valid", 32'(judge_valid), 1);
      chk("perf_code", 32'(judge_code), 1);
      chk("perf_lane", 32'(judge_lane), 0);
      chk("perf_score", 32'(score), 100);
      chk("perf_combo", 32'(combo), 1);
      chk("perf_addr_strobe", 32'(addr), 0);
      cyc(1'b0, 1'b0, 3'b000);
      chk("perf_addr_after", 32'(addr), 1);

      // GOOD late (+5) and early (-4)
      do_reset();
      cyc(1'b1, 1'b0, 3'b000);
      run_to(76);
      cyc(1'b0, 1'b0, 3'b001);
      cyc(1'b0, 1'b0, 3'b000);
      chk("good_late_code", 32'(judge_code), 2);
      chk("good_late_score", 32'(score), 50);
      do_reset();
      cyc(1'b1, 1'b0, 3'b000);
      run_to(67);
      cyc(1'b0, 1'b0, 3'b001);
      cyc(1'b0, 1'b0, 3'b000);
      chk("good_early_code", 32'(judge_code), 2);
      chk("good_early_score", 32'(score), 50);

      // MISS once frame 78 is reached
      do_reset();
      cyc(1'b1, 1'b0, 3'b000);
      run_to(77);
      cyc(1'b0, 1'b0, 3'b000);
      chk("miss_none_at_77", 32'(judge_valid), 0);
      run_to(78);
      cyc(1'b0, 1'b0, 3'b000);
      chk("miss_valid", 32'(judge_valid), 1);
      chk("miss_code", 32'(judge_code), 3);
      chk("miss_lane", 32'(judge_lane), 0);
      chk("miss_combo", 32'(combo), 0);
      cyc(1'b0, 1'b0, 3'b000);
      chk("miss_addr", 32'(addr), 1);

      // Chord: lanes 1 and 2 at frame 50, pressed together
      load_chart(16'h4032, 16'h8032, 16'h01F4, 16'h01F4);
      do_reset();
      cyc(1'b1, 1'b0, 3'b000);
      run_to(50);
      cyc(1'b0, 1'b0, 3'b110);
      cyc(1'b0, 1'b0, 3'b000);
      chk("chord1_code", 32'(judge_code), 1);
      chk("chord1_lane", 32'(judge_lane), 1);
      cyc(1'b0, 1'b0, 3'b000);
      chk("chord2_valid", 32'(judge_valid), 1);
      chk("chord2_code", 32'(judge_code), 1);
      chk("chord2_lane", 32'(judge_lane), 2);
      chk("chord2_combo", 32'(combo), 2);

      // Ghost press on lane 1 with only lane-0 notes around
      load_chart(16'h000A, 16'h0032, 16'h0064, 16'h0096);
      do_reset();
      cyc(1'b1, 1'b0, 3'b000);
      run_to(10);
      cyc(1'b0, 1'b0, 3'b001);
      cyc(1'b0, 1'b0, 3'b000);
      run_to(12);
      cyc(1'b0, 1'b0, 3'b010);
      cyc(1'b0, 1'b0, 3'b000);
`ifdef NOTE_JUDGE_GHOST_EN
      chk("ghost_valid", 32'(judge_valid), 1);
      chk("ghost_code", 32'(judge_code), 3);
      chk("ghost_lane", 32'(judge_lane), 1);
      chk("ghost_combo", 32'(combo), 0);
`else
      chk("ghost_valid", 32'(judge_valid), 0);
      chk("ghost_code", 32'(judge_code), 0);
      chk("ghost_combo", 32'(combo), 1);
`endif
      chk("ghost_score", 32'(score), 100);

      // Whole chart judged -> DONE; padding (lanes 0..2 at frame 70) never judged
      load_chart(16'h000A, 16'h4014, 16'h801E, 16'h0028);
      do_reset();
      cyc(1'b1, 1'b0, 3'b000);
      run_to(10); cyc(1'b0, 1'b0, 3'b001);
      run_to(20); cyc(1'b0, 1'b0, 3'b010);
      run_to(30); cyc(1'b0, 1'b0, 3'b100);
      run_to(40); cyc(1'b0, 1'b0, 3'b001);
      for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 3'b000);
      chk("done_flag", 32'(done), 1);
      chk("done_score", 32'(score), 400);
      chk("done_combo", 32'(combo), 4);
      chk("done_addr", 32'(addr), 4);
      cyc(1'b0, 1'b1, 3'b111);
      cyc(1'b0, 1'b0, 3'b000);
      chk("done_press_dropped", 32'(judge_valid), 0);

      // Restart from DONE, score once, then reset mid-song
      cyc(1'b1, 1'b0, 3'b000);
      chk("restart_frame", 32'(frame_cnt), 0);
      chk("restart_done", 32'(done), 0);
      run_to(10); cyc(1'b0, 1'b0, 3'b001);
      run_to(15);
      chk("pre_reset_score", 32'(score), 100);
      do_reset();
      chk("midrst_score", 32'(score), 0);
      chk("midrst_combo", 32'(combo), 0);
      chk("midrst_frame", 32'(frame_cnt), 0);
      chk("midrst_lane", 32'(judge_lane), 0);
      cyc(1'b0, 1'b1, 3'b000);
      chk("idle_no_tick", 32'(frame_cnt), 0);
      cyc(1'b1, 1'b0, 3'b000);
      cyc(1'b0, 1'b1, 3'b000);
      cyc(1'b0, 1'b1, 3'b000);
      chk("after_restart_frame", 32'(frame_cnt), 2);

      // Randomized charts and stimulus against the model
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 8; i++)
            mem[i] = {2'($urandom_range(0, 3)), 14'($urandom_range(3, 60))};
         do_reset();
         cyc(1'b1, 1'b0, 3'b000);
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 299) == 0) begin
               do_reset();
            end else begin
               cyc(($urandom_range(0, 149) == 0),
                   ($urandom_range(0, 1) == 1),
                   {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0)});
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
